// File: rtl/alu_wide_seq.sv
// alu_wide_seq: runs one NBYTES-wide ADD/ADDC/SUB/SUBC/AND/OR as a series of
// 8-bit passes through an external ALU. The passes go LSB first, and each byte's
// carry/borrow is chained into the next byte. Wide C/Z/N flags are built from
// the byte flags and held until the next operation.
// Optional feature macro: ALU_SEQ_PERF_EN adds a saturating op_count output.
// The opcode encodings normally come from defines.sv. The fallbacks below are
// used only when that file has not been compiled first.
//
// Handshake: start is a request that is sampled only while busy=0. If the op
// is supported, the request is accepted on that edge and busy rises. If it is
// not, err pulses for one cycle. A start seen while busy (RUN or DONE) is
// dropped, not queued. done is a one-cycle pulse, and result/flags are valid
// from that cycle onward.
`ifndef ADD_FN
  `define ADD_FN  3'b000
`endif
`ifndef ADDC_FN
  `define ADDC_FN 3'b001
`endif
`ifndef SUB_FN
  `define SUB_FN  3'b010
`endif
`ifndef SUBC_FN
  `define SUBC_FN 3'b011
`endif
`ifndef AND_FN
  `define AND_FN  3'b100
`endif
`ifndef OR_FN
  `define OR_FN   3'b101
`endif

module alu_wide_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [8*NBYTES-1:0]   result,
  output logic                  c_flag,
  output logic                  z_flag,
  output logic                  n_flag,
  output logic [7:0]            alu_in1,
  output logic [7:0]            alu_in2,
  output logic                  alu_c_in,
  output logic [2:0]            alu_opcode,
  input  logic [7:0]            alu_out,
  input  logic                  alu_c_out,
  input  logic                  alu_z_out,
  input  logic                  alu_n_out,
`ifdef ALU_SEQ_PERF_EN
  output logic [15:0]           op_count,
`endif
  output logic [1:0]            state_dbg
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state, state_n;
  logic [IW-1:0]         idx;
  logic [IW+2:0]         bit_off;
  logic [8*NBYTES-1:0]   a_r, b_r, res_r;
  logic [2:0]            op_r;
  logic                  carry_r, z_acc, n_r;
  logic                  first_byte, op_ok, op_arith;

  assign op_ok = (op == `ADD_FN) || (op == `ADDC_FN) || (op == `SUB_FN) ||
                 (op == `SUBC_FN) || (op == `AND_FN) || (op == `OR_FN);
  assign op_arith = (op_r != `AND_FN) && (op_r != `OR_FN);
  assign first_byte = (idx == '0);
  assign bit_off = {idx, 3'b000};
  assign busy = (state != S_IDLE);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state: accept a supported op, walk the bytes, spend one cycle in DONE.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start && op_ok) state_n = S_RUN;
      S_RUN:  if (idx == LAST) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: latch operands, collect byte results and flags, then publish in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= `ADD_FN;
      idx     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      z_acc   <= 1'b1;
      n_r     <= 1'b0;
      result  <= '0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      n_flag  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_ok) begin
              a_r   <= a;
              b_r   <= b;
              op_r  <= op;
              idx   <= '0;
              z_acc <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          res_r[bit_off +: 8] <= alu_out;
          carry_r <= alu_c_out;
          z_acc   <= z_acc & alu_z_out;
          n_r     <= alu_n_out;
          if (idx != LAST) idx <= idx + 1'b1;
        end
        S_DONE: begin
          result <= res_r;
          z_flag <= z_acc;
          n_flag <= n_r;
          if (op_arith) c_flag <= carry_r;
          done <= 1'b1;
          idx  <= '0;
        end
        default: ;
      endcase
    end
  end

  // ALU drives: only the current byte during RUN, otherwise parked at reset values.
  always_comb begin
    alu_in1    = 8'h00;
    alu_in2    = 8'h00;
    alu_c_in   = 1'b0;
    alu_opcode = `ADD_FN;
    if (state == S_RUN) begin
      alu_in1 = a_r[bit_off +: 8];
      alu_in2 = b_r[bit_off +: 8];
      case (op_r)
        `ADD_FN: begin
          alu_opcode = first_byte ? `ADD_FN : `ADDC_FN;
          alu_c_in   = first_byte ? 1'b0 : carry_r;
        end
        `ADDC_FN: begin
          alu_opcode = `ADDC_FN;
          alu_c_in   = first_byte ? c_flag : carry_r;
        end
        `SUB_FN: begin
          alu_opcode = first_byte ? `SUB_FN : `SUBC_FN;
          alu_c_in   = first_byte ? 1'b0 : carry_r;
        end
        `SUBC_FN: begin
          alu_opcode = `SUBC_FN;
          alu_c_in   = first_byte ? c_flag : carry_r;
        end
        default: begin
          alu_opcode = op_r;
          alu_c_in   = 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Completed-operation counter, saturating; rejected ops are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count <= 16'h0000;
    else if (state == S_DONE && op_count != 16'hFFFF) op_count <= op_count + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_alu_wide_seq.sv
// Testbench for alu_wide_seq (NBYTES=4) with a byte ALU model attached.
`ifndef ADD_FN
  `define ADD_FN  3'b000
`endif
`ifndef ADDC_FN
  `define ADDC_FN 3'b001
`endif
`ifndef SUB_FN
  `define SUB_FN  3'b010
`endif
`ifndef SUBC_FN
  `define SUBC_FN 3'b011
`endif
`ifndef AND_FN
  `define AND_FN  3'b100
`endif
`ifndef OR_FN
  `define OR_FN   3'b101
`endif

module tb_alu_wide_seq;
  localparam int NB = 4;
  localparam int W  = 35;  // {c, z, n, result[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_i = `ADD_FN;
  logic [31:0] a_i = '0, b_i = '0;
  logic        busy, done, err, c_flag, z_flag, n_flag;
  logic [31:0] result;
  logic [7:0]  alu_in1, alu_in2, alu_out;
  logic        alu_c_in, alu_c_out, alu_z_out, alu_n_out;
  logic [2:0]  alu_opcode;
  logic [1:0]  state_dbg;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] op_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         mdl_c = 1'b0, mdl_z = 1'b0, mdl_n = 1'b0;
  logic [31:0]  mdl_res = '0;
  int           exp_count = 0;

  alu_wide_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .err(err), .result(result),
    .c_flag(c_flag), .z_flag(z_flag), .n_flag(n_flag),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_c_in(alu_c_in), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_c_out(alu_c_out), .alu_z_out(alu_z_out), .alu_n_out(alu_n_out),
`ifdef ALU_SEQ_PERF_EN
    .op_count(op_count),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // 8-bit ALU model; carry out on subtract is the borrow
  always_comb begin
    logic [8:0] t;
    t = 9'h000;
    case (alu_opcode)
      `ADD_FN:  t = {1'b0, alu_in1} + {1'b0, alu_in2};
      `ADDC_FN: t = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'h00, alu_c_in};
      `SUB_FN:  t = {1'b0, alu_in1} - {1'b0, alu_in2};
      `SUBC_FN: t = {1'b0, alu_in1} - {1'b0, alu_in2} - {8'h00, alu_c_in};
      `AND_FN:  t = {1'b0, alu_in1 & alu_in2};
      `OR_FN:   t = {1'b0, alu_in1 | alu_in2};
      default:  t = 9'h000;
    endcase
    alu_out   = t[7:0];
    alu_c_out = t[8];
    alu_z_out = (t[7:0] == 8'h00);
    alu_n_out = t[7];
  end

  // Whole-word reference: plain 33-bit arithmetic on the full operands
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [31:0] x, y, input logic cin);
    logic [32:0] t;
    logic        c;
    t = '0;
    c = cin;
    case (o)
      `ADD_FN:  begin t = {1'b0, x} + {1'b0, y};               c = t[32]; end
      `ADDC_FN: begin t = {1'b0, x} + {1'b0, y} + 33'(cin);    c = t[32]; end
      `SUB_FN:  begin t = {1'b0, x} - {1'b0, y};               c = t[32]; end
      `SUBC_FN: begin t = {1'b0, x} - {1'b0, y} - 33'(cin);    c = t[32]; end
      `AND_FN:  t = {1'b0, x & y};
      `OR_FN:   t = {1'b0, x | y};
      default:  t = '0;
    endcase
    return {c, (t[31:0] == 32'h0), t[31], t[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_drives(input string tag);
    check({tag, "_alu_in1"}, 64'(alu_in1), 64'h0);
    check({tag, "_alu_in2"}, 64'(alu_in2), 64'h0);
    check({tag, "_alu_cin"}, 64'(alu_c_in), 64'h0);
    check({tag, "_alu_opc"}, 64'(alu_opcode), 64'(`ADD_FN));
  endtask

  task automatic check_held(input string tag);
    check({tag, "_result"}, 64'(result), 64'(mdl_res));
    check({tag, "_c"}, 64'(c_flag), 64'(mdl_c));
    check({tag, "_z"}, 64'(z_flag), 64'(mdl_z));
    check({tag, "_n"}, 64'(n_flag), 64'(mdl_n));
  endtask

  task automatic check_perf();
`ifdef ALU_SEQ_PERF_EN
    check("op_count", 64'(op_count), 64'(exp_count));
`endif
  endtask

  // Driver: one operation; poke=1 also raises start during RUN and during DONE
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, y, input bit poke);
    logic [W-1:0] e;
    int lat, busy_cnt, extra_dones;
    exp_q.push_back(model(o, x, y, mdl_c));
    @(negedge clk);
    start = 1'b1; op_i = o; a_i = x; b_i = y;
    @(posedge clk); #1;
    start = 1'b0; op_i = 3'($urandom_range(0, 7)); a_i = $urandom; b_i = $urandom;
    lat = -1; busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin lat = k; break; end
      if (busy) busy_cnt++;
      start = poke && (k == 2 || k == 4);
      if (start) op_i = `ADD_FN;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_latency", 64'(lat), 64'(NB + 1));
    check("busy_cycles", 64'(busy_cnt), 64'(NB + 1));
    check("busy_at_done", 64'(busy), 64'h0);
    e = exp_q.pop_front();
    if (lat >= 0) begin
      exp_count++;
      mdl_c = e[34]; mdl_z = e[33]; mdl_n = e[32]; mdl_res = e[31:0];
    end
    check_held("op");
    check_perf();
    extra_dones = 0;
    for (int k = 0; k < (poke ? 8 : 2); k++) begin
      @(posedge clk); #1;
      if (done || busy) extra_dones++;
    end
    check("no_extra_activity", 64'(extra_dones), 64'h0);
    check_idle_drives("idle");
  endtask

  // Driver: unsupported opcode
  task automatic do_bad_op(input logic [2:0] o);
    @(negedge clk);
    start = 1'b1; op_i = o; a_i = $urandom; b_i = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", 64'(err), 64'h1);
    check("err_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    check("err_one_cycle", 64'(err), 64'h0);
    check("err_no_done", 64'(done), 64'h0);
    check_held("err_held");
    check_perf();
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          dcount;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check_held("rst");
    check_idle_drives("rst");
    check_perf();
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with literal expectations
    do_op(`ADD_FN, 32'h000000FF, 32'h00000001, 1'b0);
    check("t1_res", 64'(result), 64'h100);
    check("t1_czn", 64'({c_flag, z_flag, n_flag}), 64'b000);
    do_op(`ADD_FN, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    check("t2_res", 64'(result), 64'h0);
    check("t2_cz", 64'({c_flag, z_flag, n_flag}), 64'b110);
    do_op(`ADDC_FN, 32'h1, 32'h1, 1'b0);
    check("t2_addc", 64'(result), 64'h3);
    do_op(`SUB_FN, 32'h0, 32'h1, 1'b0);
    check("t3_res", 64'(result), 64'hFFFFFFFF);
    check("t3_nz", 64'({z_flag, n_flag}), 64'b01);
    do_op(`AND_FN, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
    check("t3_and", 64'(result), 64'h0);
    check("t3_and_zc", 64'({c_flag, z_flag}), 64'b11);
    do_op(`OR_FN, 32'h12340000, 32'h00005678, 1'b1);
    check("t4_or", 64'(result), 64'h12345678);
    do_bad_op(3'b111);
    do_bad_op(3'b110);

    // Reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op_i = `ADD_FN; a_i = 32'h11111111; b_i = 32'h22222222;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    mdl_c = 1'b0; mdl_z = 1'b0; mdl_n = 1'b0; mdl_res = '0; exp_count = 0;
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_done", 64'(done), 64'h0);
    check_held("rst_mid");
    check_perf();
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    check("rst_mid_no_done", 64'(dcount), 64'h0);
    do_op(`ADD_FN, 32'h0000FFFF, 32'h00000001, 1'b0);
    check("t5_res", 64'(result), 64'h00010000);

    // Randomized operations against the whole-word model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0:       ra = 32'h0;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
      if (ro == 3'd6) do_bad_op(3'b110);
      else            do_op(ro, ra, rb, ($urandom_range(0, 4) == 0));
    end

`ifdef ALU_SEQ_PERF_EN
    // Counter clears on reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_count = 0; mdl_c = 1'b0; mdl_z = 1'b0; mdl_n = 1'b0; mdl_res = '0;
    check_perf();
    @(negedge clk);
    rst = 1'b0;
`endif

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
